// File: rtl/tick_prescaler_if.sv
// tick_prescaler_if: divisor-update handshake between a host (master) and the prescaler (slave).
//   i_div_valid : host offers a new divisor
//   i_div       : offered divisor, period = i_div + 1 enabled cycles
//   o_div_ready : prescaler can accept a divisor (no update pending)
interface tick_prescaler_if #(parameter int WIDTH = 16);
  logic             i_div_valid;
  logic [WIDTH-1:0] i_div;
  logic             o_div_ready;
  modport master (output i_div_valid, i_div, input o_div_ready);
  modport slave (input i_div_valid, i_div, output o_div_ready);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: programmable tick generator emitting one registered pulse every divisor+1 enabled cycles.
//   i_clock  : sole clock, rising edge
//   i_reset  : asynchronous active-low reset
//   i_ce     : count enable; phase advances only when high
//   div_bus  : divisor handshake (slave side of tick_prescaler_if)
//   o_tick   : one-cycle pulse in the cycle after each terminal cycle
//   o_phase  : current phase, 0..active divisor
//   i_restart: synchronous restart, present only when TICK_PRESCALER_RESTART_EN is defined
module tick_prescaler #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] INIT_DIV = '0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_ce,
`ifdef TICK_PRESCALER_RESTART_EN
  input  logic                  i_restart,
`endif
  tick_prescaler_if.slave       div_bus,
  output logic                  o_tick,
  output logic [WIDTH-1:0]      o_phase
);
  logic [WIDTH-1:0] active_div, shadow_div;
  logic             pending, restart, terminal, xfer, apply;
`ifdef TICK_PRESCALER_RESTART_EN
  assign restart = i_restart;
`else
  assign restart = 1'b0;
`endif
  assign terminal           = i_ce && (o_phase == active_div);
  assign xfer               = div_bus.i_div_valid && !pending;
  // The shadow only becomes active at a period boundary (or restart), so a running period is never cut short.
  assign apply              = pending && (terminal || restart);
  assign div_bus.o_div_ready = !pending;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_phase    <= '0;
      active_div <= INIT_DIV;
      shadow_div <= INIT_DIV;
      pending    <= 1'b0;
      o_tick     <= 1'b0;
    end else begin
      o_tick  <= terminal && !restart;
      o_phase <= (restart || terminal) ? '0 : i_ce ? o_phase + WIDTH'(1) : o_phase;
      if (apply) begin
        active_div <= shadow_div;
        pending    <= 1'b0;
      end
      // A capture is only possible with pending clear, so it never collides with apply.
      if (xfer) begin
        shadow_div <= div_bus.i_div;
        pending    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tick_prescaler.sv
// tb_tick_prescaler: directed scoreboard bench for tick_prescaler with INIT_DIV=3.
module tb_tick_prescaler;
  localparam int W = 16;
  typedef struct {
    string      tag;
    logic       tick;
    logic       ready;
    logic [W-1:0] phase;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce = 1'b0;
  logic         rs = 1'b0;
  logic [W-1:0] phase;
  logic         tick;
  int           n_cmp = 0;
  int           n_bad = 0;
  exp_t         q[$];
  tick_prescaler_if #(.WIDTH(W)) bus ();
  tick_prescaler #(.WIDTH(W), .INIT_DIV(16'd3)) dut (
    .i_clock  (clk),
    .i_reset  (rst_n),
    .i_ce     (ce),
`ifdef TICK_PRESCALER_RESTART_EN
    .i_restart(rs),
`endif
    .div_bus  (bus.slave),
    .o_tick   (tick),
    .o_phase  (phase)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic t, input logic r, input logic [W-1:0] p);
    n_cmp++;
    if (tick !== t || bus.o_div_ready !== r || phase !== p) begin
      n_bad++;
      $display("FAIL %s: got tick=%b ready=%b phase=%0d, want tick=%b ready=%b phase=%0d",
               tag, tick, bus.o_div_ready, phase, t, r, p);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, e.tick, e.ready, e.phase);
    end
  end
  task automatic step(input string tag, input logic c, input logic v, input logic [W-1:0] d,
                      input logic r, input logic t, input logic rd, input int p);
    exp_t e;
    @(negedge clk);
    ce = c;
    bus.i_div_valid = v;
    bus.i_div = d;
    rs = r;
    e.tag = tag; e.tick = t; e.ready = rd; e.phase = W'(p);
    q.push_back(e);
  endtask
  initial begin
    bus.i_div_valid = 1'b0;
    bus.i_div = '0;
    #2;
    chk("reset_state", 1'b0, 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++)
      step("init_div3", 1, 0, 0, 0, (i % 4) == 0, 1, i % 4);
    for (int i = 0; i < 8; i++)
      step("ce_toggle", i[0] == 0, 0, 0, 0, i == 6, 1, (i + 2) / 2 % 4);
    step("c_ph1", 1, 0, 0, 0, 0, 1, 1);
    step("c_write1", 1, 1, 1, 0, 0, 0, 2);
    step("c_ignored5", 1, 1, 5, 0, 0, 0, 3);
    step("c_apply", 1, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++)
      step("c_period2", 1, 0, 0, 0, i[0], 1, i[0] ? 0 : 1);
    step("d_write0", 1, 1, 0, 0, 0, 0, 1);
    step("d_apply0", 1, 0, 0, 0, 1, 1, 0);
    step("d_div0_a", 1, 0, 0, 0, 1, 1, 0);
    step("d_div0_ce0", 0, 0, 0, 0, 0, 1, 0);
    step("d_div0_b", 1, 0, 0, 0, 1, 1, 0);
    step("d_write4_term", 1, 1, 4, 0, 1, 0, 0);
    step("d_apply4", 1, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 5; i++)
      step("d_period5", 1, 0, 0, 0, i == 5, 1, i % 5);
    step("e_ph1", 1, 0, 0, 0, 0, 1, 1);
    step("e_write2", 1, 1, 2, 0, 0, 0, 2);
    @(negedge clk);
    ce = 1'b0;
    bus.i_div_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 1'b0, 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++)
      step("e_after_reset", 1, 0, 0, 0, i == 4, 1, i % 4);
`ifdef TICK_PRESCALER_RESTART_EN
    step("f_write7", 1, 1, 7, 0, 0, 0, 1);
    step("f_ph2", 1, 0, 0, 0, 0, 0, 2);
    step("f_ph3", 1, 0, 0, 0, 0, 0, 3);
    step("f_apply7", 1, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 4; i++)
      step("f_count", 1, 0, 0, 0, 0, 1, i);
    step("f_write2", 1, 1, 2, 0, 0, 0, 5);
    step("f_restart", 1, 0, 0, 1, 0, 1, 0);
    step("f_p3_a", 1, 0, 0, 0, 0, 1, 1);
    step("f_p3_b", 1, 0, 0, 0, 0, 1, 2);
    step("f_p3_c", 1, 0, 0, 0, 1, 1, 0);
`endif
    @(negedge clk);
    ce = 1'b0;
    bus.i_div_valid = 1'b0;
    rs = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tick_prescaler.md
TICK_PRESCALER -- requirements
Module: tick_prescaler

Interface
REQ-001 Parameter WIDTH, default 16: width of divisor and phase counter.
REQ-002 Parameter INIT_DIV, default 16'd0: divisor loaded at reset; period = INIT_DIV+1 enabled cycles.
REQ-003 Port i_clock  input  1  sole clock; all state on rising edge.
REQ-004 Port i_reset  input  1  reset, asynchronous, active-low.
REQ-005 Port i_ce  input  1  count enable; phase advances only when high.
REQ-006 Port i_div_valid  input  1  new divisor offered.
REQ-007 Port i_div  input  WIDTH  offered divisor value (period = i_div+1).
REQ-008 Port o_div_ready  output  1  high when a new divisor can be accepted.
REQ-009 Port o_tick  output  1  registered one-cycle pulse per period; drives a downstream counter's enable.
REQ-010 Port o_phase  output  WIDTH  current phase value, 0..active divisor.

Function
REQ-011 Internal state SHALL be: phase, active divisor, shadow divisor, pending flag, o_tick register.
REQ-012 Terminal cycle SHALL be defined as i_ce=1 and phase==active divisor.
REQ-013 On an enabled non-terminal cycle, phase SHALL increment by 1.
REQ-014 On a terminal cycle, phase SHALL become 0.
REQ-015 With i_ce=0, phase, active divisor and o_tick-generation SHALL hold; o_tick SHALL be 0 next cycle.
REQ-016 o_tick SHALL be 1 exactly in the cycle after a terminal cycle, else 0 (latency 1).
REQ-017 Active divisor 0 SHALL give o_tick=1 every cycle following an enabled cycle; phase stays 0.
REQ-018 Divisor transfer SHALL occur when i_div_valid=1 and o_div_ready=1 in the same cycle; i_div is then captured into shadow and pending set.
REQ-019 o_div_ready SHALL equal NOT pending; i_div_valid while not ready SHALL be ignored (no capture).
REQ-020 On a terminal cycle with pending=1, active divisor SHALL take shadow, pending clears, o_div_ready rises next cycle.
REQ-021 A transfer in a terminal cycle with pending=0 SHALL NOT affect that cycle; the new value applies at the following terminal cycle.
REQ-022 A new active divisor SHALL never truncate a period in progress; applies from phase 0 only.
REQ-023 Phase arithmetic SHALL be unsigned WIDTH bits; phase never exceeds active divisor, so no wrap past 2^WIDTH-1 occurs.
REQ-024 With divisor 2^WIDTH-1, period SHALL be 2^WIDTH enabled cycles.

Reset
REQ-025 i_reset low SHALL immediately, independent of i_clock: phase=0, active=INIT_DIV, shadow=INIT_DIV, pending=0, o_tick=0, o_div_ready=1.
REQ-026 Reset mid-period or with pending=1 SHALL discard pending value and partial period.
REQ-027 First terminal cycle after reset release SHALL be the (INIT_DIV+1)th enabled cycle.

Configuration
REQ-028 Macro TICK_PRESCALER_RESTART_EN SHALL control a synchronous restart input i_restart (1 bit).
REQ-029 With macro defined: i_restart=1 SHALL set phase=0, suppress o_tick next cycle, apply pending shadow immediately and clear pending, regardless of i_ce; i_restart wins over a simultaneous terminal cycle.
REQ-030 With macro defined: a transfer coinciding with i_restart SHALL be captured as pending (not applied that cycle).
REQ-031 Without macro: port i_restart SHALL not exist; behaviour exactly as REQ-011..REQ-027.

Verification
REQ-032 INIT_DIV=3, i_ce=1 constant after reset -> o_tick high cycles 4, 8, 12 after release; o_phase 0,1,2,3,0 sequence.
REQ-033 INIT_DIV=3, i_ce toggled 1,0 every cycle -> o_tick once per 8 clocks; o_phase holds on i_ce=0 cycles.
REQ-034 Divisor 3, write i_div=1 at phase 1 -> o_div_ready low until after next terminal; then ticks every 2 cycles; second write during pending ignored.
REQ-035 Divisor 0 -> o_tick=1 every cycle; write i_div=4 -> next tick, then period 5.
REQ-036 Assert i_reset low mid-period with pending=1 -> all outputs at reset values without clock edge; pending value never used.
REQ-037 With TICK_PRESCALER_RESTART_EN, divisor 7, pulse i_restart at phase 5 with pending=2 -> phase 0, no tick next cycle, then period 3.
